nhan_cong_mac: RTL and testbench

//  Sequential multiply-accumulate: accepts a stream of (A,B) operand pairs and returns
//  P = sum(A_i*B_i) over the stream, ending at the pair flagged in_last.

---
 rtl/nhan_cong_mac.sv | 126 ++++++++++++
 tb/tb_nhan_cong_mac.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/nhan_cong_mac.sv
`default_nettype none
// ============================================================================
// Module   : nhan_cong_mac
// Purpose  : Sequential multiply-accumulate. Takes a stream of unsigned (A,B)
//            pairs and returns P = sum(A_i*B_i). The dot product ends at the
//            pair flagged in_last. A single radix-2 shift-add multiplier is
//            reused for every term, so each pair takes W+2 cycles.
// Ports    : clk, rst         - clock (rising edge), async active-high reset
//            A, B             - W-bit unsigned operands
//            in_last          - pair closes the current dot product
//            in_valid/ready   - operand handshake
//            P                - ACCW-bit result, valid while out_valid, else 0
//            ovf              - sticky carry-out of the accumulator
//            out_valid/ready  - result handshake
// Revision : 1.0 - initial release
// ============================================================================
module nhan_cong_mac #(
  parameter int W    = 4,
  parameter int ACCW = 2*W+1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [W-1:0]    A,
  input  logic [W-1:0]    B,
  input  logic            in_last,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [ACCW-1:0] P,
  output logic            ovf,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W-1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic            last_reg;
  logic [2*W-1:0]  prod;
  logic [CW-1:0]   cnt;
  logic [ACCW-1:0] acc;

  // Partial-product term for the current multiplier bit.
  logic [2*W-1:0]  a_shift;
  logic            b_bit;
  // Product resized to the accumulator width; truncates only when ACCW < 2W.
  logic [ACCW-1:0] prod_ext;
  // One extra bit captures the carry that feeds the sticky overflow flag.
  logic [ACCW:0]   sum;

  assign a_shift  = {{W{1'b0}}, a_reg} << cnt;
  assign b_bit    = b_reg[cnt];
  assign prod_ext = ACCW'(prod);
  assign sum      = {1'b0, acc} + {1'b0, prod_ext};

  assign in_ready = (state == IDLE);
  assign P        = out_valid ? acc : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      last_reg  <= 1'b0;
      prod      <= '0;
      cnt       <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= A;
            b_reg    <= B;
            last_reg <= in_last;
            prod     <= '0;
            cnt      <= '0;
            state    <= MUL;
          end
        end
        MUL: begin
          // Fixed W iterations regardless of operand values.
          if (b_bit) begin
            prod <= prod + a_shift;
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= ACC;
          end
        end
        ACC: begin
          acc <= sum[ACCW-1:0];
          ovf <= ovf | sum[ACCW];
          if (last_reg) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            state <= IDLE;
          end
        end
        DONE: begin
          // Result held until the consumer takes it; then start a fresh sum.
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            ovf       <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nhan_cong_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_nhan_cong_mac
// Purpose  : Directed self-checking bench for nhan_cong_mac (W=4, ACCW=9).
// Revision : 1.0 - initial release
// ============================================================================
module tb_nhan_cong_mac;

  localparam int W    = 4;
  localparam int ACCW = 2*W+1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [W-1:0]    A = '0;
  logic [W-1:0]    B = '0;
  logic            in_last = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [ACCW-1:0] P;
  logic            ovf;
  logic            out_valid;
  logic            out_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int results_taken = 0;

  nhan_cong_mac #(.W(W), .ACCW(ACCW)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .P(P), .ovf(ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Count completed result handshakes.
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) results_taken <= results_taken + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one pair and return #1 after the edge that accepts it.
  task automatic send(input int a, input int b, input bit last);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 0, 1);
    A        = W'(a);
    B        = W'(b);
    in_last  = last;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called right after the last pair's accept edge: measures latency,
  // checks P/ovf, then takes the result and checks the return to IDLE.
  task automatic get_result(input string tag, input int exp_p, input int exp_ovf);
    int lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, lat, W+1);
    check({tag, "_P"}, int'(P), exp_p);
    check({tag, "_ovf"}, int'(ovf), exp_ovf);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, int'(out_valid), 0);
    check({tag, "_P_zero"}, int'(P), 0);
    check({tag, "_in_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_P", int'(P), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_ovf", int'(ovf), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);

    // 1: 12*2 + 10*3 = 54
    send(12, 2, 1'b0);
    send(10, 3, 1'b1);
    get_result("t1", 54, 0);
    check("t1_once", results_taken, 1);

    // 2: 225 + 150 = 375, then a fresh 24
    send(15, 15, 1'b0);
    send(15, 10, 1'b1);
    get_result("t2a", 375, 0);
    send(4, 6, 1'b1);
    get_result("t2b", 24, 0);

    // 3: 675 mod 512 = 163 with overflow; next sum starts clean
    send(15, 15, 1'b0);
    send(15, 15, 1'b0);
    send(15, 15, 1'b1);
    get_result("t3", 163, 1);
    send(1, 1, 1'b1);
    get_result("t3_next", 1, 0);

    // 4: hold result with out_ready low; input pulses must be ignored
    send(9, 5, 1'b1);
    repeat (W+1) @(posedge clk);
    #1;
    check("t4_valid", int'(out_valid), 1);
    for (int i = 0; i < 6; i++) begin
      A = 4'd3; B = 4'd3; in_last = 1'b1; in_valid = i[0];
      @(posedge clk);
      #1;
      check("t4_hold_P", int'(P), 45);
      check("t4_hold_valid", int'(out_valid), 1);
      check("t4_hold_ovf", int'(ovf), 0);
      check("t4_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("t4_release_valid", int'(out_valid), 0);
    check("t4_release_in_ready", int'(in_ready), 1);

    // 5: reset in the middle of a multiply
    send(7, 7, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t5_rst_P", int'(P), 0);
    check("t5_rst_valid", int'(out_valid), 0);
    check("t5_rst_ovf", int'(ovf), 0);
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_valid) check("t5_spurious_valid", 1, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t5_in_ready", int'(in_ready), 1);
    send(8, 3, 1'b1);
    get_result("t5", 24, 0);

    // 6: zero operands, same latency
    send(0, 9, 1'b1);
    get_result("t6a", 0, 0);
    send(14, 0, 1'b1);
    get_result("t6b", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
